// File: rtl/lbp_img_host_pkg.sv
// Shared constants, FSM state encoding and the border predicate used by the
// image host and the LBP core.
package lbp_img_host_pkg;

    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;
    localparam int DEF_AW    = 14;
    localparam int DEF_DW    = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Row/col split assumes a power-of-two width, so the column is the low bits.
    function automatic logic is_border(input logic [31:0] addr, input int w_log2, input int h);
        logic [31:0] row, col, col_max;
        col_max = (32'd1 << w_log2) - 32'd1;
        row     = addr >> w_log2;
        col     = addr & col_max;
        return (row == 32'd0) || (row == 32'(h - 1)) || (col == 32'd0) || (col == col_max);
    endfunction

endpackage

// File: rtl/lbp_img_host_frame_ram.sv
// Dual-array frame store: gray image and LBP result, one write port each,
// asynchronous read ports.
module lbp_frame_ram #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          img_we_i,
    input  logic [AW-1:0] img_waddr_i,
    input  logic [DW-1:0] img_wdata_i,
    input  logic [AW-1:0] img_raddr_i,
    output logic [DW-1:0] img_rdata_o,
    input  logic          res_we_i,
    input  logic [AW-1:0] res_waddr_i,
    input  logic [DW-1:0] res_wdata_i,
    input  logic [AW-1:0] res_raddr_i,
    output logic [DW-1:0] res_rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] img_mem [DEPTH];
    logic [DW-1:0] res_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (img_we_i) img_mem[img_waddr_i] <= img_wdata_i;
        if (res_we_i) res_mem[res_waddr_i] <= res_wdata_i;
    end

    assign img_rdata_o = img_mem[img_raddr_i];
    assign res_rdata_o = res_mem[res_raddr_i];

endmodule

// File: rtl/lbp_img_host.sv
// Image-side responder for the LBP engine: loads the gray frame, serves reads,
// captures results and streams them back out after finish.
module lbp_img_host
    import lbp_img_host_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic [AW-1:0] gray_addr,
    input  logic          gray_req,
    output logic          gray_ready,
    output logic [DW-1:0] gray_data,
    input  logic [AW-1:0] lbp_addr,
    input  logic          lbp_valid,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic          done,
    output logic          err
);

    localparam int            W_LOG2 = $clog2(IMG_W);
    localparam logic [AW-1:0] LAST   = AW'(IMG_W * IMG_H - 1);

    state_e        state_q;
    logic [AW-1:0] ld_cnt_q, drain_cnt_q;
    logic          ld_ready_q, gray_ready_q, out_valid_q, done_q, err_q;

    logic          in_load, in_serve, border_wr;
    logic          res_we;
    logic [AW-1:0] res_waddr;
    logic [DW-1:0] res_wdata;

    assign in_load   = (state_q == ST_LOAD);
    assign in_serve  = (state_q == ST_SERVE);
    assign border_wr = is_border(32'(lbp_addr), W_LOG2, IMG_H);

    // Loading also zeroes the result array so untouched border pixels drain as 0.
    assign res_we    = (in_load && ld_valid) || (in_serve && lbp_valid);
    assign res_waddr = in_load ? ld_cnt_q : lbp_addr;
    assign res_wdata = in_load ? '0 : lbp_data;

    lbp_frame_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk         (clk),
        .img_we_i    (in_load && ld_valid),
        .img_waddr_i (ld_cnt_q),
        .img_wdata_i (ld_data),
        .img_raddr_i (gray_addr),
        .img_rdata_o (gray_data),
        .res_we_i    (res_we),
        .res_waddr_i (res_waddr),
        .res_wdata_i (res_wdata),
        .res_raddr_i (drain_cnt_q),
        .res_rdata_o (out_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            ld_cnt_q     <= '0;
            drain_cnt_q  <= '0;
            ld_ready_q   <= 1'b1;
            gray_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if ((lbp_valid && (!in_serve || border_wr)) || (gray_req && !gray_ready_q))
                err_q <= 1'b1;
            case (state_q)
                ST_LOAD: if (ld_valid) begin
                    ld_cnt_q <= ld_cnt_q + 1'b1;
                    if (ld_cnt_q == LAST) begin
                        state_q      <= ST_SERVE;
                        ld_ready_q   <= 1'b0;
                        gray_ready_q <= 1'b1;
                    end
                end
                ST_SERVE: if (finish) begin
                    state_q      <= ST_DRAIN;
                    gray_ready_q <= 1'b0;
                    out_valid_q  <= 1'b1;
                end
                ST_DRAIN: if (out_ready) begin
                    drain_cnt_q <= drain_cnt_q + 1'b1;
                    if (drain_cnt_q == LAST) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ld_ready   = ld_ready_q;
    assign gray_ready = gray_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_valid_q && (drain_cnt_q == LAST);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lbp_img_host.sv
// Directed bench for lbp_img_host: vector tables for reads/writes plus
// hand-written drain stall and mid-drain reset sequences.
module tb_lbp_img_host;

    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [13:0] gray_addr;
    logic        gray_req;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic [13:0] lbp_addr;
    logic        lbp_valid;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        out_last;
    logic        done;
    logic        err;

    lbp_img_host dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .gray_addr(gray_addr), .gray_req(gray_req), .gray_ready(gray_ready), .gray_data(gray_data),
        .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [13:0] addr; logic [7:0] exp; } gray_vec_t;
    typedef struct { logic [13:0] addr; logic [7:0] data; } wr_vec_t;

    gray_vec_t gvec [6];
    wr_vec_t   wvec [5];
    logic [7:0] res_m [N];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int a, input int mode);
        logic [31:0] v;
        case (mode)
            0:       v = a;
            1:       v = a ^ 32'h55;
            default: v = a * 3;
        endcase
        return v[7:0];
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ld_ready"},   ld_ready,   1);
        chk({tag, "_gray_ready"}, gray_ready, 0);
        chk({tag, "_out_valid"},  out_valid,  0);
        chk({tag, "_out_last"},   out_last,   0);
        chk({tag, "_done"},       done,       0);
        chk({tag, "_err"},        err,        0);
    endtask

    task automatic do_load(input int mode);
        for (int a = 0; a < N; a++) begin
            ld_valid = 1'b1;
            ld_data  = pix(a, mode);
            if (a == N - 1) chk("ld_ready_at_last_byte", ld_ready, 1);
            step();
        end
        ld_valid = 1'b0;
        chk("ld_ready_after_load", ld_ready, 0);
        chk("gray_ready_after_load", gray_ready, 1);
    endtask

    // Drains bytes [start, stop) with out_ready held high, scoring against res_m.
    task automatic do_drain(input int start, input int stop);
        int idx, bad, nlast, lastpos, cyc, first_bad;
        idx = start; bad = 0; nlast = 0; lastpos = -1; cyc = 0; first_bad = -1;
        out_ready = 1'b1;
        while (idx < stop && cyc < N + 100) begin
            if (out_valid) begin
                if (out_data !== res_m[idx]) begin
                    bad++;
                    if (first_bad < 0) first_bad = idx;
                end
                if (out_last) begin
                    nlast++;
                    lastpos = idx;
                end
                idx++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_byte_count", idx, stop);
        chk("drain_data_bad_bytes", bad, 0);
        if (bad != 0) $display("  first differing drain index %0d", first_bad);
        if (stop == N) begin
            chk("out_last_count", nlast, 1);
            chk("out_last_position", lastpos, N - 1);
        end else begin
            chk("out_last_count_partial", nlast, 0);
        end
    endtask

    initial begin
        gvec[0] = '{14'd129,   8'h81};
        gvec[1] = '{14'd0,     8'h00};
        gvec[2] = '{14'd255,   8'hFF};
        gvec[3] = '{14'd256,   8'h00};
        gvec[4] = '{14'd1000,  8'hE8};
        gvec[5] = '{14'd16383, 8'hFF};
        wvec[0] = '{14'd129,   8'h11};
        wvec[1] = '{14'd130,   8'h22};
        wvec[2] = '{14'd8000,  8'h5A};
        wvec[3] = '{14'd254,   8'h7E};
        wvec[4] = '{14'd16129, 8'hC3};

        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; gray_addr = '0; gray_req = 1'b0;
        lbp_addr = '0; lbp_valid = 1'b0; lbp_data = '0; finish = 1'b0; out_ready = 1'b0;
        step(); step();
        chk_reset_outputs("reset0");
        reset = 1'b0;

        // Run 1: ramp load, reads, interior and border writes, stalled drain.
        do_load(0);
        gray_req = 1'b1;
        foreach (gvec[i]) begin
            gray_addr = gvec[i].addr;
            #1;
            chk($sformatf("gray_data_addr%0d", gvec[i].addr), gray_data, gvec[i].exp);
            step();
        end
        gray_req = 1'b0;

        for (int a = 0; a < N; a++) res_m[a] = 8'h00;
        foreach (wvec[i]) begin
            lbp_valid = 1'b1; lbp_addr = wvec[i].addr; lbp_data = wvec[i].data;
            res_m[wvec[i].addr] = wvec[i].data;
            step();
        end
        lbp_valid = 1'b0;
        chk("err_after_legal_traffic", err, 0);

        lbp_valid = 1'b1; lbp_addr = 14'd0; lbp_data = 8'h3C; res_m[0] = 8'h3C;
        step();
        lbp_addr = 14'd1; lbp_data = 8'h5E; res_m[1] = 8'h5E;
        step();
        lbp_valid = 1'b0;
        chk("err_border_write", err, 1);
        step(); step(); step();
        chk("err_sticky", err, 1);
        chk("still_serving", gray_ready, 1);

        lbp_valid = 1'b1; lbp_addr = 14'd16254; lbp_data = 8'hA5; finish = 1'b1;
        res_m[16254] = 8'hA5;
        step();
        lbp_valid = 1'b0; finish = 1'b0;
        chk("drain_entered_out_valid", out_valid, 1);
        chk("drain_entered_gray_ready", gray_ready, 0);

        chk("drain_b0", out_data, 8'h3C);
        out_ready = 1'b1;
        step();
        chk("drain_b1", out_data, 8'h5E);
        out_ready = 1'b0;
        step();
        chk("drain_stall1_hold", out_data, 8'h5E);
        chk("drain_stall1_valid", out_valid, 1);
        step();
        chk("drain_stall2_hold", out_data, 8'h5E);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain_b2_after_stall", out_data, 8'h00);
        chk("drain_b2_not_last", out_last, 0);
        do_drain(2, N);
        chk("done_after_last", done, 1);
        chk("done_out_valid", out_valid, 0);
        chk("done_ld_ready", ld_ready, 0);
        chk("done_gray_ready", gray_ready, 0);
        step(); step();
        chk("done_sticky", done, 1);

        // Run 2: write outside SERVE, then reset in the middle of the drain.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_outputs("reset_from_done");
        lbp_valid = 1'b1; lbp_addr = 14'd300; lbp_data = 8'h99;
        step();
        lbp_valid = 1'b0;
        chk("err_lbp_in_load", err, 1);
        do_load(1);
        gray_req = 1'b1; gray_addr = 14'd129;
        #1;
        chk("gray_data_run2", gray_data, 8'hD4);
        step();
        gray_req = 1'b0;
        finish = 1'b1;
        step();
        finish = 1'b0;
        for (int a = 0; a < N; a++) res_m[a] = 8'h00;
        do_drain(0, 5000);
        reset = 1'b1;
        step();
        chk_reset_outputs("reset_mid_drain");
        reset = 1'b0;

        // Run 3: early gray_req, fresh load, full drain must be all zero.
        gray_req = 1'b1; gray_addr = 14'd0;
        step();
        gray_req = 1'b0;
        chk("err_gray_req_before_ready", err, 1);
        do_load(2);
        gray_req = 1'b1; gray_addr = 14'd1000;
        #1;
        chk("gray_data_run3", gray_data, 8'hB8);
        step();
        gray_req = 1'b0;
        finish = 1'b1;
        step();
        finish = 1'b0;
        do_drain(0, N);
        chk("done_run3", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbp_img_host.md
Name: lbp_img_host

Overview:
- Image-side responder for the LBP engine's gray-read and lbp-write interface.
- Loads a 128x128 8-bit gray image from a byte stream into internal storage and serves the engine's gray_addr/gray_req reads with same-cycle data.
- Captures lbp_valid writes into a result memory whose border is pre-cleared, then streams the full 128x128 result out after the engine asserts finish.
- Sits between the system/host byte streams and the LBP core, and replaces the bench-only memory model in integrated builds.

Parameters:
- IMG_W, 128, image width in pixels; must be a power of two.
- IMG_H, 128, image height in pixels.
- AW, 14, address width; log2(IMG_W*IMG_H).
- DW, 8, pixel and LBP code width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  load-stream byte valid.
- ld_data  in  DW  gray pixel, raster order starting at address 0.
- ld_ready  out  1  load stream accepts a byte this cycle.
- gray_addr  in  AW  pixel read address from the LBP core.
- gray_req  in  1  LBP core read request.
- gray_ready  out  1  image loaded; core may start requesting.
- gray_data  out  DW  pixel at gray_addr.
- lbp_addr  in  AW  result write address.
- lbp_valid  in  1  result write strobe; one cycle per write.
- lbp_data  in  DW  LBP code.
- finish  in  1  core done; level signal.
- out_valid  out  1  result-stream byte valid.
- out_data  out  DW  result byte, raster order.
- out_ready  in  1  downstream accepts the byte.
- out_last  out  1  marks address IMG_W*IMG_H-1.
- done  out  1  result fully drained; sticky until reset.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: state=LOAD, ld_cnt=0, drain_cnt=0. Outputs: ld_ready=1, gray_ready=0, out_valid=0, out_last=0, done=0, err=0.
- Memory contents are not reset.

States:
- LOAD:
  - ld_ready=1.
  - On ld_valid, write img[ld_cnt]<=ld_data and res[ld_cnt]<=0 (clears the border), then ld_cnt++.
  - After accepting byte IMG_W*IMG_H-1, go to SERVE on the next cycle; ld_ready drops in that same cycle.
- SERVE:
  - gray_ready=1.
  - gray_data = img[gray_addr] combinationally (zero-latency). The core registers gray_addr and samples gray_data on the next edge.
  - gray_data is don't-care while gray_req=0.
  - On lbp_valid, write res[lbp_addr]<=lbp_data in that cycle.
  - When finish=1, go to DRAIN. If lbp_valid and finish are high in the same cycle, the write completes first and the state still moves to DRAIN.
- DRAIN:
  - gray_ready=0.
  - out_valid=1 and out_data=res[drain_cnt] combinationally.
  - out_last=1 when drain_cnt==IMG_W*IMG_H-1.
  - drain_cnt advances only on out_valid&&out_ready; out_data holds while stalled.
  - After the last handshake, go to DONE.
- DONE:
  - done=1, out_valid=0, all ready signals 0.
  - Only reset leaves DONE.

err is set (sticky) on any of:
- lbp_valid outside SERVE;
- lbp_valid to a border address (row 0, row IMG_H-1, col 0 or col IMG_W-1);
- gray_req while gray_ready=0.
- An illegal write is still performed in SERVE and ignored in all other states.

Address arithmetic:
- row = addr[AW-1:log2(IMG_W)], col = addr[log2(IMG_W)-1:0]. No wrap checks beyond AW bits.

Reset mid-operation:
- Any state returns to LOAD with counters cleared.
- The result memory is re-cleared during the next load.

Decomposition:
- Shared package: state enum (LOAD/SERVE/DRAIN/DONE), IMG_W/IMG_H/AW/DW defaults, and the border-address predicate function.
- The LBP core uses the same package constants.
- One natural sub-module: lbp_frame_ram, a dual-array RAM (img, res) with one write port per array and combinational read ports.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then stream 16384 bytes with img[a]=a[7:0] and ld_valid held high:
  - ld_ready falls after byte 16383;
  - gray_ready=1 on the following cycle;
  - gray_addr=129 gives gray_data=0x81.
- Full run with the LBP core on a ramp image:
  - 15876 writes, err=0;
  - drained res[0..127]=0 and res[16256..16383]=0;
  - interior bytes match the golden LBP file;
  - out_last only at byte 16383.
- lbp_valid at lbp_addr=0 during SERVE:
  - err=1 and stays 1;
  - res[0] is overwritten;
  - flow continues to DRAIN on finish.
- lbp_valid and finish in the same cycle with lbp_addr=16254, data 0xA5 -> res[16254]=0xA5 is drained and state reaches DRAIN.
- DRAIN with out_ready toggled 1,0,0,1 -> out_data holds during stalls, no byte is skipped or duplicated, and done=1 one cycle after the last handshake.
- Reset asserted at byte 5000 of DRAIN, then a fresh load -> all outputs return to their reset values and res is cleared (border drains as 0).
